name_scroller: RTL and testbench

Sequencer for the team's 4-bit-code-to-segment letter decoders. It holds a short message of 4-bit character codes and time-multiplexes them onto a bank of display digits. It scrolls the message one position at a time at a programmable rate and presents one code plus a one-hot digit enable per scan slot. The `code` output feeds the decoder inputs `x0..x3` directly, and the decoder's `f0..f6` go to the shared segment lines.

---
 rtl/name_scroller_if.sv | 36 +++
 rtl/name_scroller.sv | 127 ++++++++++++
 tb/tb_name_scroller.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/name_scroller_if.sv
// name_scroller_if: groups the message-write port, the start/stop controls and
// the display outputs of name_scroller into one bundle.
//   master : drives wr_en/wr_addr/wr_data/start/stop, observes the outputs
//   slave  : the scroller itself
// Signals:
//   wr_en, wr_addr[AW], wr_data[4] - message buffer write
//   start, stop                    - one-cycle control pulses
//   busy, code[4], digit_en[ND],   - display outputs
//   blank, wrap
interface name_scroller_if #(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN    = 8
);
  localparam int AW = $clog2(MSG_LEN);

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [3:0]            wr_data;
  logic                  start;
  logic                  stop;
  logic                  busy;
  logic [3:0]            code;
  logic [NUM_DIGITS-1:0] digit_en;
  logic                  blank;
  logic                  wrap;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop,
    input  busy, code, digit_en, blank, wrap
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop,
    output busy, code, digit_en, blank, wrap
  );
endinterface

// File: rtl/name_scroller.sv
// name_scroller: holds a message of 4-bit character codes and time-multiplexes
// it onto NUM_DIGITS display digits, scrolling one position every SCROLL_DIV
// frames. code feeds the letter decoder x0..x3 inputs; digit_en is the one-hot
// digit select.
// Ports:
//   clk    - rising-edge clock
//   resetn - asynchronous active-low reset (clears FSM, counters and message)
//   bus    - name_scroller_if.slave: write port, start/stop, display outputs
module name_scroller #(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN    = 8,
  parameter int SCAN_DIV   = 1000,
  parameter int SCROLL_DIV = 250
) (
  input  logic            clk,
  input  logic            resetn,
  name_scroller_if.slave  bus
);

  localparam int AW  = $clog2(MSG_LEN);
  localparam int DW  = $clog2(NUM_DIGITS);
  localparam int SW  = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int FW  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(SCROLL_DIV - 1);
  localparam logic [AW-1:0] POS_LAST   = AW'(MSG_LEN - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] digit;
  logic [FW-1:0] frame_cnt;
  logic [AW-1:0] pos;
  logic          wrap_r;
  logic [3:0]    msg [MSG_LEN];
  logic [AW-1:0] rd_idx;
  logic          run_step;

  // stop has priority over start; start in RUN is a restart (RUN -> RUN)
  always_comb begin
    state_nxt = state;
    if (bus.stop)
      state_nxt = IDLE;
    else if (bus.start)
      state_nxt = RUN;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Counters only advance on an undisturbed RUN cycle; any start, stop or
  // IDLE cycle leaves them at zero, which also gives restart its clean slate.
  assign run_step = (state == RUN) && !bus.start && !bus.stop;

  // ---- counter chain: scan -> digit -> frame -> pos ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scan_cnt  <= '0;
      digit     <= '0;
      frame_cnt <= '0;
      pos       <= '0;
      wrap_r    <= 1'b0;
    end else if (run_step) begin
      wrap_r <= 1'b0;
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        if (digit == DIGIT_LAST) begin
          digit <= '0;
          if (frame_cnt == FRAME_LAST) begin
            frame_cnt <= '0;
            pos       <= pos + AW'(1);
            // registered alongside pos so the pulse lines up with pos = 0
            wrap_r    <= (pos == POS_LAST);
          end else begin
            frame_cnt <= frame_cnt + FW'(1);
          end
        end else begin
          digit <= digit + DW'(1);
        end
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
    end else begin
      scan_cnt  <= '0;
      digit     <= '0;
      frame_cnt <= '0;
      pos       <= '0;
      wrap_r    <= 1'b0;
    end
  end

  // ---- message buffer: writable in any state, independent of counters ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MSG_LEN; i++)
        msg[i] <= 4'h0;
    end else if (bus.wr_en) begin
      msg[bus.wr_addr] <= bus.wr_data;
    end
  end

  // ---- outputs: decoded from registered state only ----
  // AW-bit addition wraps naturally modulo MSG_LEN (a power of two).
  assign rd_idx = pos + AW'(digit);

  always_comb begin
    bus.busy     = 1'b0;
    bus.blank    = 1'b1;
    bus.code     = 4'h0;
    bus.digit_en = '0;
    bus.wrap     = wrap_r;
    if (state == RUN) begin
      bus.busy     = 1'b1;
      bus.blank    = 1'b0;
      bus.code     = msg[rd_idx];
      bus.digit_en = NUM_DIGITS'(1) << digit;
    end
  end

endmodule

// File: tb/tb_name_scroller.sv
module tb_name_scroller;

  localparam int ND = 4;
  localparam int ML = 8;
  localparam int SD = 2;
  localparam int RD = 2;
  localparam int FRAME = SD * ND;
  localparam int STEP  = FRAME * RD;
  localparam int FULL  = STEP * ML;

  logic clk;
  logic resetn;

  name_scroller_if #(.NUM_DIGITS(ND), .MSG_LEN(ML)) bus ();

  name_scroller #(
    .NUM_DIGITS(ND), .MSG_LEN(ML), .SCAN_DIV(SD), .SCROLL_DIV(RD)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic [3:0] en;
    logic [3:0] code;
    logic       blank;
    logic       wrap;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: elapsed cycles since the last start plus a plain array.
  bit   m_run = 0;
  int   m_t   = 0;
  int   m_msg [ML];

  function automatic exp_t model_out();
    exp_t e;
    int d, p;
    e = '{busy: 1'b0, en: 4'b0, code: 4'h0, blank: 1'b1, wrap: 1'b0};
    if (m_run) begin
      d = (m_t / SD) % ND;
      p = (m_t / STEP) % ML;
      e.busy  = 1'b1;
      e.blank = 1'b0;
      e.en    = 4'(1 << d);
      e.code  = 4'(m_msg[(p + d) % ML]);
      e.wrap  = (m_t > 0) && (m_t % FULL == 0);
    end
    return e;
  endfunction

  function automatic void model_reset();
    m_run = 0;
    m_t   = 0;
    for (int i = 0; i < ML; i++) m_msg[i] = 0;
  endfunction

  // Applies inputs for the next rising edge and queues the expected result.
  task automatic cycle(input bit st, input bit sp, input bit we,
                       input int wa, input int wd);
    @(negedge clk);
    bus.start   = st;
    bus.stop    = sp;
    bus.wr_en   = we;
    bus.wr_addr = 3'(wa);
    bus.wr_data = 4'(wd);
    if (!resetn) begin
      model_reset();
    end else begin
      if (we) m_msg[wa % ML] = wd & 15;
      if (sp)
        m_run = 0;
      else if (st) begin
        m_run = 1;
        m_t   = 0;
      end else if (m_run)
        m_t++;
    end
    q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  // Asserts reset between edges: one expectation for the immediate effect,
  // one for the following edge.
  task automatic apply_reset();
    @(negedge clk);
    bus.start = 0; bus.stop = 0; bus.wr_en = 0;
    model_reset();
    q.push_back(model_out());
    q.push_back(model_out());
    resetn = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #3;
    resetn = 1'b1;
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h required %0h", nm, $time, act, req);
    end
  endtask

  // Monitor: one expectation per rising edge or asynchronous reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge resetn);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("busy",     int'(bus.busy),     int'(e.busy));
        chk("digit_en", int'(bus.digit_en), int'(e.en));
        chk("code",     int'(bus.code),     int'(e.code));
        chk("blank",    int'(bus.blank),    int'(e.blank));
        chk("wrap",     int'(bus.wrap),     int'(e.wrap));
      end
    end
  end

  initial begin
    int r;
    resetn      = 1'b0;
    bus.start   = 0;
    bus.stop    = 0;
    bus.wr_en   = 0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    model_reset();

    idle(3);
    release_reset();
    idle(3);

    // Load 1..8 and scroll through a full wrap and beyond.
    for (int i = 0; i < ML; i++) cycle(0, 0, 1, i, i + 1);
    cycle(1, 0, 0, 0, 0);
    idle(140);

    // Restart, then live-write index 2 while digit 0 shows it (pos 2).
    cycle(1, 0, 0, 0, 0);
    idle(32);
    cycle(0, 0, 1, 2, 15);
    idle(16);

    // Restart at pos 3.
    cycle(0, 0, 1, 2, 3);
    idle(2);
    cycle(1, 0, 0, 0, 0);
    idle(3 * STEP + 3);
    cycle(1, 0, 0, 0, 0);
    idle(10);

    // Stop in the middle of a digit slot, then resume.
    idle(2);
    cycle(0, 1, 0, 0, 0);
    idle(3);
    cycle(1, 1, 0, 0, 0);
    idle(3);
    cycle(1, 0, 0, 0, 0);
    idle(40);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 999);
      cycle(r < 10, (r >= 10 && r < 16), ($urandom_range(0, 3) == 0),
            $urandom_range(0, ML - 1), $urandom_range(0, 15));
    end

    // Reset mid-RUN, then verify the message was cleared.
    cycle(1, 0, 0, 0, 0);
    idle(20);
    apply_reset();
    idle(2);
    release_reset();
    idle(2);
    cycle(1, 0, 0, 0, 0);
    idle(FULL + 4);
    idle(2);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
